// File: rtl/f2fx_pkg.sv
// Shared constants and types for the float-to-fixed converter.
// Default widths describe IEEE-754 single precision feeding a Q15.16 output.
package f2fx_pkg;

  localparam int DEF_W    = 32;
  localparam int DEF_EW   = 8;
  localparam int DEF_SW   = 23;
  localparam int DEF_FW   = 32;
  localparam int DEF_FRAC = 16;
  localparam int BIAS     = 127;

  // Saturation limits for the default output width
  localparam logic [DEF_FW-1:0] MAX_POS = {1'b0, {(DEF_FW-1){1'b1}}};
  localparam logic [DEF_FW-1:0] MIN_NEG = {1'b1, {(DEF_FW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/float_to_fixed_converter_if.sv
// Start/ack handshake and data bus between the requester and the converter.
// The requester drives through master; the converter through slave.
interface float_to_fixed_converter_if #(
  parameter int W  = f2fx_pkg::DEF_W,
  parameter int FW = f2fx_pkg::DEF_FW
);
  logic          beg_fsm;
  logic          ack_fsm;
  logic [W-1:0]  data_in;
  logic [FW-1:0] data_out;
  logic          ready;
  logic          overflow;

  modport master (
    output beg_fsm, ack_fsm, data_in,
    input  data_out, ready, overflow
  );

  modport slave (
    input  beg_fsm, ack_fsm, data_in,
    output data_out, ready, overflow
  );
endinterface

// File: rtl/f2fx_shift_sat.sv
// Combinational exponent decode and mantissa shift. Produces the unsigned
// magnitude plus flags the sign stage needs to saturate correctly:
//   o_ovfProv : magnitude would not fit as a positive result (or inf/NaN)
//   o_exact   : magnitude is exactly 2^(FW-1), legal only when negative
//   o_nan     : operand is NaN, result forced to zero
module f2fx_shift_sat
  import f2fx_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int EW   = DEF_EW,
  parameter int SW   = DEF_SW,
  parameter int FW   = DEF_FW,
  parameter int FRAC = DEF_FRAC
) (
  input  logic [W-2:0]  i_expMant,
  output logic [FW-1:0] o_mag,
  output logic          o_ovfProv,
  output logic          o_exact,
  output logic          o_nan
);

  localparam int SHW  = EW + 2;
  localparam int MW   = SW + 1;
  localparam int WIDE = MW + FW;
  localparam logic [FW-1:0] SAT_POS = {1'b0, {(FW-1){1'b1}}};
  localparam logic [FW-1:0] SAT_NEG = {1'b1, {(FW-1){1'b0}}};

  logic [EW-1:0]         w_exp;
  logic [SW-1:0]         w_mant;
  logic [MW-1:0]         w_m;
  logic signed [SHW-1:0] w_sh;
  logic [SHW-1:0]        w_nsh;
  logic [WIDE-1:0]       w_wide;
  logic                  w_huge;

  assign w_exp  = i_expMant[W-2 -: EW];
  assign w_mant = i_expMant[SW-1:0];
  assign w_m    = {1'b1, w_mant};
  assign w_sh   = $signed({2'b00, w_exp}) - $signed(SHW'(BIAS - FRAC + SW));

  // Shift the hidden-bit mantissa into fixed-point position; left shifts use a
  // wide intermediate so bits pushed past FW are detected instead of wrapping
  always_comb begin
    w_wide    = '0;
    w_huge    = 1'b0;
    w_nsh     = '0;
    o_mag     = '0;
    o_ovfProv = 1'b0;
    o_exact   = 1'b0;
    o_nan     = 1'b0;
    if (w_exp == '0) begin
      o_mag = '0;
    end else if (w_exp == '1) begin
      o_nan     = (w_mant != '0);
      o_ovfProv = 1'b1;
    end else if (!w_sh[SHW-1]) begin
      if (w_sh >= $signed(SHW'(FW))) begin
        w_huge = 1'b1;
      end else begin
        w_wide = WIDE'(w_m) << $unsigned(w_sh);
        w_huge = |w_wide[WIDE-1:FW];
      end
      o_mag     = w_wide[FW-1:0];
      o_ovfProv = w_huge | (w_wide[FW-1:0] > SAT_POS);
      o_exact   = !w_huge && (w_wide[FW-1:0] == SAT_NEG);
    end else begin
      w_nsh = SHW'(-w_sh);
      if (w_nsh < SHW'(MW)) begin
        o_mag = FW'(w_m >> w_nsh);
      end
    end
  end

endmodule

// File: rtl/float_to_fixed_converter.sv
// Multicycle IEEE-754 to signed fixed-point converter with start/ack handshake.
// IDLE captures the operand, SHIFT registers the magnitude, SIGN applies the
// sign and saturation, DONE presents the result until acknowledged.
module float_to_fixed_converter
  import f2fx_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int EW   = DEF_EW,
  parameter int SW   = DEF_SW,
  parameter int FW   = DEF_FW,
  parameter int FRAC = DEF_FRAC
) (
  input logic                       clk,
  input logic                       rst,
  float_to_fixed_converter_if.slave bus
);

  localparam logic [FW-1:0] SAT_POS = {1'b0, {(FW-1){1'b1}}};
  localparam logic [FW-1:0] SAT_NEG = {1'b1, {(FW-1){1'b0}}};

  state_t        r_state;
  logic [W-1:0]  r_operand;
  logic [FW-1:0] r_mag;
  logic          r_ovfProv;
  logic          r_exact;
  logic          r_nan;
  logic [FW-1:0] r_dataOut;
  logic          r_ready;
  logic          r_overflow;

  logic [FW-1:0] w_mag;
  logic          w_ovfProv;
  logic          w_exact;
  logic          w_nan;

  f2fx_shift_sat #(
    .W(W), .EW(EW), .SW(SW), .FW(FW), .FRAC(FRAC)
  ) u_shiftSat (
    .i_expMant (r_operand[W-2:0]),
    .o_mag     (w_mag),
    .o_ovfProv (w_ovfProv),
    .o_exact   (w_exact),
    .o_nan     (w_nan)
  );

  // Handshake FSM with registered datapath stages and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_operand  <= '0;
      r_mag      <= '0;
      r_ovfProv  <= 1'b0;
      r_exact    <= 1'b0;
      r_nan      <= 1'b0;
      r_dataOut  <= '0;
      r_ready    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.beg_fsm) begin
            r_operand <= bus.data_in;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_mag     <= w_mag;
          r_ovfProv <= w_ovfProv;
          r_exact   <= w_exact;
          r_nan     <= w_nan;
          r_state   <= SIGN;
        end
        SIGN: begin
          if (r_nan) begin
            r_dataOut  <= '0;
            r_overflow <= 1'b1;
          end else if (!r_ovfProv) begin
            r_dataOut  <= r_operand[W-1] ? -r_mag : r_mag;
            r_overflow <= 1'b0;
          end else if (r_operand[W-1] && r_exact) begin
            r_dataOut  <= SAT_NEG;
            r_overflow <= 1'b0;
          end else begin
            r_dataOut  <= r_operand[W-1] ? SAT_NEG : SAT_POS;
            r_overflow <= 1'b1;
          end
          r_ready <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (bus.ack_fsm) begin
            r_ready <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_out = r_dataOut;
  assign bus.ready    = r_ready;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_float_to_fixed_converter.sv
// Bench for float_to_fixed_converter: directed cases with known answers,
// handshake corner cases, asynchronous reset, then random operands checked
// against a real-arithmetic reference model.
module tb_float_to_fixed_converter;
  import f2fx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  float_to_fixed_converter_if #(.W(32), .FW(32)) bus ();

  float_to_fixed_converter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports and counts a failure
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value = (1 + mant/2^23) * 2^(exp-127), scaled by 2^16,
  // truncated toward zero, saturated to the signed 32-bit range
  function automatic void refModel(input logic [31:0] op, output logic [31:0] expData,
                                   output logic expOvf);
    int    e;
    logic  neg;
    real   scaled;
    real   lim;
    longint mag;
    e      = int'(op[30:23]);
    neg    = op[31];
    expData = 32'h0;
    expOvf  = 1'b0;
    if (e == 0) begin
      expData = 32'h0;
      expOvf  = 1'b0;
    end else if (e == 255) begin
      expOvf  = 1'b1;
      expData = (op[22:0] != 0) ? 32'h0 : (neg ? MIN_NEG : MAX_POS);
    end else begin
      scaled = (1.0 + real'(op[22:0]) / 8388608.0) * (2.0 ** (e - 127)) * 65536.0;
      lim    = neg ? 2147483649.0 : 2147483648.0;
      if (scaled >= lim) begin
        expData = neg ? MIN_NEG : MAX_POS;
        expOvf  = 1'b1;
      end else begin
        mag     = longint'($floor(scaled));
        expData = neg ? 32'(-mag) : 32'(mag);
      end
    end
  endfunction

  // Start one conversion and count edges (including the sampling edge) until ready
  task automatic applyStimulus(input logic [31:0] op, output int latency);
    @(negedge clk);
    bus.data_in = op;
    bus.beg_fsm = 1'b1;
    @(posedge clk);
    #1;
    bus.beg_fsm = 1'b0;
    latency = 1;
    while (bus.ready !== 1'b1 && latency < 10) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  // Check a finished conversion, then acknowledge and check ready drops with data held
  task automatic checkOutput(input string tag, input int latency,
                             input logic [31:0] expData, input logic expOvf);
    checkVal({tag, " latency"}, 32'(latency), 32'd3);
    checkVal({tag, " ready"}, 32'(bus.ready), 32'd1);
    checkVal({tag, " data"}, bus.data_out, expData);
    checkVal({tag, " ovf"}, 32'(bus.overflow), 32'(expOvf));
    @(negedge clk);
    bus.ack_fsm = 1'b1;
    @(posedge clk);
    #1;
    bus.ack_fsm = 1'b0;
    checkVal({tag, " ready after ack"}, 32'(bus.ready), 32'd0);
    checkVal({tag, " data held"}, bus.data_out, expData);
  endtask

  typedef struct {
    string       name;
    logic [31:0] op;
    logic [31:0] data;
    logic        ovf;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    int          lat;
    logic [31:0] op;
    logic [31:0] eData;
    logic        eOvf;

    vecs.push_back('{"one",      32'h3F80_0000, 32'h0001_0000, 1'b0});
    vecs.push_back('{"m2p5",     32'hC020_0000, 32'hFFFD_8000, 1'b0});
    vecs.push_back('{"lsb",      32'h3780_0000, 32'h0000_0001, 1'b0});
    vecs.push_back('{"sublsb",   32'h3700_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{"big",      32'h471C_4000, 32'h7FFF_FFFF, 1'b1});
    vecs.push_back('{"m32768",   32'hC700_0000, 32'h8000_0000, 1'b0});
    vecs.push_back('{"p32768",   32'h4700_0000, 32'h7FFF_FFFF, 1'b1});
    vecs.push_back('{"pinf",     32'h7F80_0000, 32'h7FFF_FFFF, 1'b1});
    vecs.push_back('{"ninf",     32'hFF80_0000, 32'h8000_0000, 1'b1});
    vecs.push_back('{"nan",      32'h7FC0_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{"negzero",  32'h8000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{"denorm",   32'h0040_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{"hugeexp",  32'h7E00_0000, 32'h7FFF_FFFF, 1'b1});
    vecs.push_back('{"mhuge",    32'hFE00_0000, 32'h8000_0000, 1'b1});

    rst         = 1'b1;
    bus.beg_fsm = 1'b0;
    bus.ack_fsm = 1'b0;
    bus.data_in = 32'h0;
    #2;
    checkVal("reset data", bus.data_out, 32'h0);
    checkVal("reset ready", 32'(bus.ready), 32'd0);
    checkVal("reset ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values with hand-derived answers
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, lat);
      checkOutput(vecs[i].name, lat, vecs[i].data, vecs[i].ovf);
    end

    // beg_fsm held through the whole conversion and together with ack in DONE
    @(negedge clk);
    bus.data_in = 32'h3F80_0000;
    bus.beg_fsm = 1'b1;
    @(posedge clk);
    #1;
    bus.data_in = 32'hC020_0000;
    lat = 1;
    while (bus.ready !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkVal("held latency", 32'(lat), 32'd3);
    checkVal("held data", bus.data_out, 32'h0001_0000);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkVal("held done waits", 32'(bus.ready), 32'd1);
    @(negedge clk);
    bus.ack_fsm = 1'b1;
    @(posedge clk);
    #1;
    checkVal("held ack ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    bus.beg_fsm = 1'b0;
    bus.ack_fsm = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkVal("held no restart", 32'(bus.ready), 32'd0);
    checkVal("held data kept", bus.data_out, 32'h0001_0000);
    applyStimulus(32'hC020_0000, lat);
    checkOutput("after held", lat, 32'hFFFD_8000, 1'b0);

    // Asynchronous reset in SHIFT after a previous result
    applyStimulus(32'h3F80_0000, lat);
    checkOutput("pre reset", lat, 32'h0001_0000, 1'b0);
    @(negedge clk);
    bus.data_in = 32'hC020_0000;
    bus.beg_fsm = 1'b1;
    @(posedge clk);
    #2;
    bus.beg_fsm = 1'b0;
    rst = 1'b1;
    #1;
    checkVal("abort data", bus.data_out, 32'h0);
    checkVal("abort ready", 32'(bus.ready), 32'd0);
    checkVal("abort ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h3780_0000, lat);
    checkOutput("post reset", lat, 32'h0000_0001, 1'b0);

    // Random operands against the reference model
    for (int n = 0; n < 60; n++) begin
      op[31]    = 1'($urandom_range(0, 1));
      op[30:23] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(100, 160));
      op[22:0]  = 23'($urandom);
      refModel(op, eData, eOvf);
      applyStimulus(op, lat);
      checkOutput($sformatf("rand%0d op=%h", n, op), lat, eData, eOvf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
